// File: rtl/synth_scaler_if.sv
// synth_scaler_if: stream bundle for synth_scaler.
//   Input side : in_valid/in_ready handshake carrying in_sample, gain, mute.
//   Output side: synth_valid/synth_ready pop interface carrying scaled_synth_code,
//                plus the underrun_cnt debug counter.
//   slave  modport: the scaler (consumes input stream, produces codes).
//   master modport: the feeder/sampler side (testbench or surrounding logic).
interface synth_scaler_if #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned GAIN_WIDTH   = 8,
  parameter int unsigned CODE_WIDTH   = 10
);
  logic                    in_valid;
  logic                    in_ready;
  logic [SAMPLE_WIDTH-1:0] in_sample;
  logic [GAIN_WIDTH-1:0]   gain;
  logic                    mute;
  logic                    synth_valid;
  logic                    synth_ready;
  logic [CODE_WIDTH-1:0]   scaled_synth_code;
  logic [15:0]             underrun_cnt;

  modport master (
    output in_valid, in_sample, gain, mute, synth_ready,
    input  in_ready, synth_valid, scaled_synth_code, underrun_cnt
  );

  modport slave (
    input  in_valid, in_sample, gain, mute, synth_ready,
    output in_ready, synth_valid, scaled_synth_code, underrun_cnt
  );
endinterface

// File: rtl/synth_scaler.sv
// synth_scaler: scales signed synth samples by a Q1.7 gain, saturates, converts
// to offset-binary DAC codes and buffers them for the sigma-delta sampler.
// Ports:
//   clk   - system clock
//   rst_n - synchronous active-low reset
//   bus   - synth_scaler_if.slave (input stream, code output, underrun counter)
// Pipeline: stage 1 registers the product, stage 2 registers the saturated
// code, the FIFO takes it on the following edge. in_ready is credit based
// (FIFO occupancy plus in-flight pipeline entries), so nothing ever stalls.
module synth_scaler #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned GAIN_WIDTH   = 8,
  parameter int unsigned CODE_WIDTH   = 10,
  parameter int unsigned DEPTH        = 4
) (
  input logic           clk,
  input logic           rst_n,
  synth_scaler_if.slave bus
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PW    = SAMPLE_WIDTH + GAIN_WIDTH + 1;
  localparam int unsigned SHIFT = 7 + SAMPLE_WIDTH - CODE_WIDTH;
  localparam logic [CODE_WIDTH-1:0] MIDSCALE = {1'b1, {(CODE_WIDTH-1){1'b0}}};

  logic                  accept, push, pop;
  logic [AW+1:0]         credit;

  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_mute_q, s1_mute_d;
  logic signed [PW-1:0]  s1_prod_q, s1_prod_d;
  logic signed [PW-1:0]  samp_ext, gain_ext;

  logic                  s2_valid_q, s2_valid_d;
  logic [CODE_WIDTH-1:0] s2_code_q, s2_code_d;
  logic signed [PW-1:0]  sh;
  logic                  fits;
  logic [CODE_WIDTH-1:0] sat;

  logic [CODE_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic [15:0]           underrun_q, underrun_d;

  // Credits count everything already committed to land in the FIFO.
  assign credit = {1'b0, count_q}
                + {{(AW+1){1'b0}}, s1_valid_q}
                + {{(AW+1){1'b0}}, s2_valid_q};
  assign bus.in_ready    = credit < (AW+2)'(DEPTH);
  assign accept          = bus.in_valid && bus.in_ready;
  assign bus.synth_valid = count_q != '0;
  assign pop             = bus.synth_valid && bus.synth_ready;
  assign push            = s2_valid_q;

  assign bus.scaled_synth_code = bus.synth_valid ? mem_q[rd_ptr_q] : MIDSCALE;
  assign bus.underrun_cnt      = underrun_q;

  // Stage 1: signed sample times zero-extended gain.
  always_comb begin
    samp_ext   = PW'($signed(bus.in_sample));
    gain_ext   = PW'(bus.gain);
    s1_valid_d = accept;
    s1_mute_d  = bus.mute;
    s1_prod_d  = samp_ext * gain_ext;
  end

  // Stage 2: floor shift, saturate to signed CODE_WIDTH, flip MSB.
  always_comb begin
    sh   = s1_prod_q >>> SHIFT;
    fits = (&sh[PW-1:CODE_WIDTH-1]) || !(|sh[PW-1:CODE_WIDTH-1]);
    if (fits) begin
      sat = sh[CODE_WIDTH-1:0];
    end else if (sh[PW-1]) begin
      sat = {1'b1, {(CODE_WIDTH-1){1'b0}}};
    end else begin
      sat = {1'b0, {(CODE_WIDTH-1){1'b1}}};
    end
    s2_valid_d = s1_valid_q;
    s2_code_d  = s1_mute_q ? MIDSCALE : {~sat[CODE_WIDTH-1], sat[CODE_WIDTH-2:0]};
  end

  // FIFO bookkeeping and underrun counter.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    underrun_d = underrun_q;
    if (bus.synth_ready && !bus.synth_valid && underrun_q != '1) begin
      underrun_d = underrun_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mute_q  <= 1'b0;
      s1_prod_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_code_q  <= MIDSCALE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      underrun_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mute_q  <= s1_mute_d;
      s1_prod_q  <= s1_prod_d;
      s2_valid_q <= s2_valid_d;
      s2_code_q  <= s2_code_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      underrun_q <= underrun_d;
    end
  end

  // Storage needs no reset: the output is forced to midscale while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s2_code_q;
    end
  end

endmodule

// File: tb/tb_synth_scaler.sv
// tb_synth_scaler: directed test of synth_scaler with a scoreboard queue.
// Expected codes come from an integer model pushed at each accepted sample
// and are compared against the FIFO head whenever a pop occurs.
module tb_synth_scaler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  synth_scaler_if #(.SAMPLE_WIDTH(16), .GAIN_WIDTH(8), .CODE_WIDTH(10)) sif ();

  synth_scaler #(
    .SAMPLE_WIDTH(16),
    .GAIN_WIDTH  (8),
    .CODE_WIDTH  (10),
    .DEPTH       (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (sif.slave)
  );

  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q[$];

  function automatic logic [9:0] model(input logic [15:0] s, input logic [7:0] g, input logic m);
    int p;
    int q;
    p = int'($signed(s)) * int'(g);
    q = p >>> 13;
    if (q > 511)  q = 511;
    if (q < -512) q = -512;
    if (m) return 10'd512;
    return 10'(q + 512);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_pop(input string tag);
    logic [9:0] e;
    if (exp_q.size() == 0) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL %s observed=pop_with_code_%0d expected=no_pop", tag, sif.scaled_synth_code);
      end
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(sif.scaled_synth_code), 32'(e));
    end
  endtask

  // One cycle: drive at negedge, record accept/pop that will happen at the next posedge.
  task automatic drive(input logic v, input logic [15:0] s, input logic [7:0] g,
                       input logic m, input logic r, output logic acc, output logic popped);
    @(negedge clk);
    sif.in_valid    = v;
    sif.in_sample   = s;
    sif.gain        = g;
    sif.mute        = m;
    sif.synth_ready = r;
    acc    = v && sif.in_ready && rst_n;
    popped = r && sif.synth_valid && rst_n;
    if (acc) exp_q.push_back(model(s, g, m));
    if (popped) check_pop("pop_code");
  endtask

  task automatic idle(input int n);
    logic a, p;
    repeat (n) drive(1'b0, '0, '0, 1'b0, 1'b0, a, p);
  endtask

  // Wait (bounded) for data, then pulse synth_ready once and compare the head.
  task automatic pop_one(input string tag);
    logic got;
    got = 1'b0;
    for (int n = 0; n < 32 && !got; n++) begin
      @(negedge clk);
      sif.in_valid    = 1'b0;
      sif.synth_ready = sif.synth_valid;
      if (sif.synth_valid) begin
        check_pop(tag);
        got = 1'b1;
      end
    end
    if (!got) check({tag, "_timeout"}, 32'(sif.synth_valid), 32'd1);
  endtask

  initial begin
    logic acc, popped;
    int nacc;

    sif.in_valid    = 1'b0;
    sif.in_sample   = '0;
    sif.gain        = '0;
    sif.mute        = 1'b0;
    sif.synth_ready = 1'b0;
    rst_n           = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(sif.synth_valid), 32'd0);
    check("rst_code", 32'(sif.scaled_synth_code), 32'd512);
    check("rst_underrun", 32'(sif.underrun_cnt), 32'd0);
    check("rst_in_ready", 32'(sif.in_ready), 32'd1);
    rst_n = 1'b1;

    // Single sample and latency.
    drive(1'b1, 16'h1000, 8'd128, 1'b0, 1'b0, acc, popped);
    check("t1_accept", 32'(acc), 32'd1);
    idle(1);
    check("t1_lat1", 32'(sif.synth_valid), 32'd0);
    idle(1);
    check("t1_lat2", 32'(sif.synth_valid), 32'd0);
    idle(1);
    check("t1_lat3", 32'(sif.synth_valid), 32'd1);
    check("t1_code", 32'(sif.scaled_synth_code), 32'd576);
    pop_one("t1_pop");
    idle(1);
    check("t1_empty_valid", 32'(sif.synth_valid), 32'd0);
    check("t1_empty_code", 32'(sif.scaled_synth_code), 32'd512);

    // Saturation and floor behaviour.
    drive(1'b1, 16'h7FFF, 8'd255, 1'b0, 1'b0, acc, popped);
    drive(1'b1, 16'h8000, 8'd255, 1'b0, 1'b0, acc, popped);
    drive(1'b1, 16'hFFFF, 8'd128, 1'b0, 1'b0, acc, popped);
    drive(1'b1, 16'h1234, 8'd0,   1'b0, 1'b0, acc, popped);
    pop_one("sat_pos");
    pop_one("sat_neg");
    pop_one("floor_m1");
    pop_one("gain_zero");
    idle(2);

    // Backpressure: exactly DEPTH accepts, then one more per pop.
    nacc = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 16'($urandom), 8'($urandom), 1'b0, 1'b0, acc, popped);
      nacc += int'(acc);
    end
    check("bp_accepts", 32'(nacc), 32'd4);
    check("bp_in_ready_low", 32'(sif.in_ready), 32'd0);
    pop_one("bp_pop");
    nacc = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'($urandom), 8'($urandom), 1'b0, 1'b0, acc, popped);
      nacc += int'(acc);
    end
    check("bp_reopen_accepts", 32'(nacc), 32'd1);
    check("bp_in_ready_low2", 32'(sif.in_ready), 32'd0);
    for (int i = 0; i < 4; i++) pop_one("bp_drain");
    idle(2);
    check("bp_drained", 32'(sif.synth_valid), 32'd0);

    // Sampler cadence: one pop every 2500 cycles, input always offered.
    for (int p = 0; p < 20; p++) begin
      for (int c = 0; c < 2499; c++) begin
        drive(1'b1, 16'($urandom), 8'($urandom), 1'b0, 1'b0, acc, popped);
      end
      drive(1'b1, 16'($urandom), 8'($urandom), 1'b0, 1'b1, acc, popped);
      check("cad_pop", 32'(popped), 32'd1);
    end
    idle(4);
    check("cad_underrun", 32'(sif.underrun_cnt), 32'd0);
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) pop_one("cad_drain");
    idle(2);
    check("cad_drained", 32'(sif.synth_valid), 32'd0);

    // Underrun counting and push landing on a ready pulse.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b1, acc, popped);
      idle(1);
    end
    check("ur_count3", 32'(sif.underrun_cnt), 32'd3);
    check("ur_code", 32'(sif.scaled_synth_code), 32'd512);
    drive(1'b1, 16'h2000, 8'd128, 1'b0, 1'b0, acc, popped);
    idle(1);
    drive(1'b0, '0, '0, 1'b0, 1'b1, acc, popped);
    check("ur_land_no_pop", 32'(popped), 32'd0);
    idle(1);
    check("ur_count4", 32'(sif.underrun_cnt), 32'd4);
    check("ur_landed_valid", 32'(sif.synth_valid), 32'd1);
    pop_one("ur_code_after");
    idle(1);
    check("ur_final_valid", 32'(sif.synth_valid), 32'd0);
    check("ur_final_count", 32'(sif.underrun_cnt), 32'd4);

    // Mute, then reset with buffered entries.
    drive(1'b1, 16'h4000, 8'd128, 1'b1, 1'b0, acc, popped);
    drive(1'b1, 16'h4000, 8'd128, 1'b1, 1'b0, acc, popped);
    pop_one("mute0");
    pop_one("mute1");
    idle(1);
    for (int i = 0; i < 3; i++) drive(1'b1, 16'($urandom), 8'($urandom), 1'b0, 1'b0, acc, popped);
    idle(3);
    check("pre_rst_valid", 32'(sif.synth_valid), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_valid", 32'(sif.synth_valid), 32'd0);
    check("mrst_code", 32'(sif.scaled_synth_code), 32'd512);
    check("mrst_in_ready", 32'(sif.in_ready), 32'd1);
    check("mrst_underrun", 32'(sif.underrun_cnt), 32'd0);
    rst_n = 1'b1;
    exp_q.delete();
    drive(1'b1, 16'hC000, 8'd64, 1'b0, 1'b0, acc, popped);
    pop_one("post_rst");
    idle(2);
    check("post_rst_empty", 32'(sif.synth_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
